uart_tx_arbiter: RTL and testbench

- Shares the single UART byte transmitter between `NUM_REQ` independent requesters using round-robin arbitration.
- Accepts one byte at a time from the granted requester and issues a one-cycle `start_send` to the transmitter.
- Waits for the transmitter's `done` pulse, then reports per-requester completion.
- Runs entirely in the `clk_baud` domain, between the protocol/console logic and the transmitter.

---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART byte transmitter between
//   NUM_REQ requesters. It captures one byte from the granted requester,
//   strobes start_send, and waits for tx_done before reporting completion.
//   All logic runs on the rising edge of clk_baud.
//
// Optional feature: define UART_TX_ARBITER_TIMEOUT_EN to abort a transfer
//   whose tx_done has not arrived TIMEOUT cycles after entering WAIT.
//   Without the macro, WAIT persists until tx_done or reset, and
//   o_timeout_err is constant 0.
//
// Ports:
//   clk_baud        baud-rate clock
//   rst             synchronous, active-low reset
//   i_req_valid     per-requester byte available
//   i_req_data      requester i byte at [8i+7:8i]
//   o_req_ready     one-cycle pulse: byte of requester i captured
//   o_req_done      one-cycle pulse: requester i byte sent (or aborted)
//   o_tx_byte       byte to transmitter, stable from capture to IDLE
//   o_start_send    one-cycle start strobe to transmitter
//   i_tx_done       transmitter completion pulse
//   o_busy          high whenever the FSM is not IDLE
//   o_grant_id      index of current or most recent grant
//   o_timeout_err   one-cycle pulse on an aborted transfer
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk_baud,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [NUM_REQ-1:0]         o_req_done,
  output logic [7:0]                 o_tx_byte,
  output logic                       o_start_send,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_timeout_err
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_last_grant;
  logic          w_any;
  logic [GW-1:0] w_pick;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait_cnt;
`endif

  // Search upward from last_grant+1, wrapping, so the most recently
  // served requester is considered last.
  always_comb begin
    logic [GW-1:0] v_idx;
    w_any  = 1'b0;
    w_pick = '0;
    v_idx  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      v_idx = GW'((32'(r_last_grant) + k) % NUM_REQ);
      if (!w_any && i_req_valid[v_idx]) begin
        w_any  = 1'b1;
        w_pick = v_idx;
      end
    end
  end

  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge clk_baud) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_last_grant  <= GW'(NUM_REQ - 1);
      o_req_ready   <= '0;
      o_req_done    <= '0;
      o_tx_byte     <= '0;
      o_start_send  <= 1'b0;
      o_grant_id    <= '0;
      o_timeout_err <= 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      r_wait_cnt    <= '0;
`endif
    end else begin
      o_req_done    <= '0;
      o_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            o_tx_byte   <= i_req_data[{w_pick, 3'b000} +: 8];
            o_grant_id  <= w_pick;
            o_req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
            r_state     <= S_START;
          end
        end
        S_START: begin
          o_req_ready  <= '0;
          o_start_send <= 1'b1;
          r_state      <= S_WAIT;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          r_wait_cnt   <= '0;
`endif
        end
        S_WAIT: begin
          o_start_send <= 1'b0;
          // tx_done wins over a simultaneous expiry: normal completion.
          if (i_tx_done) begin
            o_req_done[o_grant_id] <= 1'b1;
            r_last_grant           <= o_grant_id;
            r_state                <= S_IDLE;
          end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
            o_timeout_err          <= 1'b1;
            o_req_done[o_grant_id] <= 1'b1;
            r_last_grant           <= o_grant_id;
            r_state                <= S_IDLE;
          end else if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk_baud;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic [7:0]  tx_byte;
  logic        start_send;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk_baud      (clk_baud),
    .rst           (rst),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .o_req_done    (req_done),
    .o_tx_byte     (tx_byte),
    .o_start_send  (start_send),
    .i_tx_done     (tx_done),
    .o_busy        (busy),
    .o_grant_id    (grant_id),
    .o_timeout_err (timeout_err)
  );

  initial clk_baud = 1'b0;
  always #5 clk_baud = ~clk_baud;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [31:0] d;
    logic        t;
    logic [3:0]  rdy;
    logic [3:0]  dn;
    logic [7:0]  byt;
    logic        st;
    logic        bsy;
    logic [1:0]  gid;
  } vec_t;

  vec_t tbl [23];

  task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d,
                      input logic t);
    rst       = r;
    req_valid = v;
    req_data  = d;
    tx_done   = t;
    @(posedge clk_baud);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] e_rdy,
                       input logic [3:0] e_dn, input logic [7:0] e_byt,
                       input logic e_st, input logic e_bsy,
                       input logic [1:0] e_gid, input logic e_terr);
    logic [20:0] act;
    logic [20:0] exp;
    act = {req_ready, req_done, tx_byte, start_send, busy, grant_id, timeout_err};
    exp = {e_rdy, e_dn, e_byt, e_st, e_bsy, e_gid, e_terr};
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy=%b done=%b byte=%h start=%b busy=%b gid=%0d terr=%b, expected rdy=%b done=%b byte=%h start=%b busy=%b gid=%0d terr=%b",
               name, req_ready, req_done, tx_byte, start_send, busy, grant_id,
               timeout_err, e_rdy, e_dn, e_byt, e_st, e_bsy, e_gid, e_terr);
    end
  endtask

  initial begin
    logic [1:0] g;
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;

    //            r  v     d              t   rdy   dn    byt    st bsy gid
    tbl[0]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 4'h1, 32'h0000_0055, 1'b0, 4'h1, 4'h0, 8'h55, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 4'h0, 8'h55, 1'b1, 1'b1, 2'd0};
    tbl[4]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 4'h0, 8'h55, 1'b0, 1'b1, 2'd0};
    tbl[5]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 4'h1, 8'h55, 1'b0, 1'b0, 2'd0};
    tbl[6]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 4'h0, 8'h55, 1'b0, 1'b0, 2'd0};
    // tx_done in IDLE and in START must be ignored
    tbl[7]  = '{1'b1, 4'h2, 32'h0000_1100, 1'b1, 4'h2, 4'h0, 8'h11, 1'b0, 1'b1, 2'd1};
    tbl[8]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 4'h0, 8'h11, 1'b1, 1'b1, 2'd1};
    tbl[9]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 4'h0, 8'h11, 1'b0, 1'b1, 2'd1};
    tbl[10] = '{1'b1, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 4'h2, 8'h11, 1'b0, 1'b0, 2'd1};
    // requester 2 served, requester 0 raised during WAIT wins next; 2 ranks lowest
    tbl[11] = '{1'b1, 4'h4, 32'h0022_0000, 1'b0, 4'h4, 4'h0, 8'h22, 1'b0, 1'b1, 2'd2};
    tbl[12] = '{1'b1, 4'h5, 32'h0022_0077, 1'b0, 4'h0, 4'h0, 8'h22, 1'b1, 1'b1, 2'd2};
    tbl[13] = '{1'b1, 4'h5, 32'h0022_0077, 1'b0, 4'h0, 4'h0, 8'h22, 1'b0, 1'b1, 2'd2};
    tbl[14] = '{1'b1, 4'h5, 32'h0022_0077, 1'b0, 4'h0, 4'h0, 8'h22, 1'b0, 1'b1, 2'd2};
    tbl[15] = '{1'b1, 4'h5, 32'h0022_0077, 1'b1, 4'h0, 4'h4, 8'h22, 1'b0, 1'b0, 2'd2};
    tbl[16] = '{1'b1, 4'h5, 32'h0022_0077, 1'b0, 4'h1, 4'h0, 8'h77, 1'b0, 1'b1, 2'd0};
    tbl[17] = '{1'b1, 4'h4, 32'h0022_0000, 1'b0, 4'h0, 4'h0, 8'h77, 1'b1, 1'b1, 2'd0};
    tbl[18] = '{1'b1, 4'h4, 32'h0022_0000, 1'b1, 4'h0, 4'h1, 8'h77, 1'b0, 1'b0, 2'd0};
    tbl[19] = '{1'b1, 4'h4, 32'h0022_0000, 1'b0, 4'h4, 4'h0, 8'h22, 1'b0, 1'b1, 2'd2};
    tbl[20] = '{1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 4'h0, 8'h22, 1'b1, 1'b1, 2'd2};
    tbl[21] = '{1'b1, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 4'h4, 8'h22, 1'b0, 1'b0, 2'd2};
    tbl[22] = '{1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 4'h0, 8'h22, 1'b0, 1'b0, 2'd2};

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].t);
      check($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].dn, tbl[i].byt,
            tbl[i].st, tbl[i].bsy, tbl[i].gid, 1'b0);
    end

    // Fairness: all valid after reset gives grants 0,1,2,3,0
    step(1'b0, 4'h0, 32'h0, 1'b0);
    check("fair_rst", 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      g = 2'(k % 4);
      step(1'b1, 4'hF, 32'hA3A2_A1A0, 1'b0);
      check($sformatf("fair%0d_grant", k), 4'h1 << g, 4'h0, 8'hA0 + 8'(g),
            1'b0, 1'b1, g, 1'b0);
      step(1'b1, 4'hF, 32'hA3A2_A1A0, 1'b0);
      check($sformatf("fair%0d_start", k), 4'h0, 4'h0, 8'hA0 + 8'(g),
            1'b1, 1'b1, g, 1'b0);
      step(1'b1, 4'hF, 32'hA3A2_A1A0, 1'b1);
      check($sformatf("fair%0d_done", k), 4'h0, 4'h1 << g, 8'hA0 + 8'(g),
            1'b0, 1'b0, g, 1'b0);
    end

    // Reset in WAIT: abort with no done; requester 0 first afterwards
    step(1'b1, 4'h2, 32'h0000_4400, 1'b0);
    check("rw_grant", 4'h2, 4'h0, 8'h44, 1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b1, 4'h0, 32'h0, 1'b0);
    check("rw_start", 4'h0, 4'h0, 8'h44, 1'b1, 1'b1, 2'd1, 1'b0);
    step(1'b1, 4'h0, 32'h0, 1'b0);
    check("rw_wait", 4'h0, 4'h0, 8'h44, 1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b1);
    check("rw_reset", 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 4'h0, 32'h0, 1'b0);
    check("rw_idle", 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 4'hF, 32'hA3A2_A1A0, 1'b0);
    check("rw_prio", 4'h1, 4'h0, 8'hA0, 1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b1, 4'h0, 32'h0, 1'b0);
    check("rw_start2", 4'h0, 4'h0, 8'hA0, 1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b1, 4'h0, 32'h0, 1'b1);
    check("rw_done", 4'h0, 4'h1, 8'hA0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Withheld tx_done
    step(1'b1, 4'h4, 32'h00CC_0000, 1'b0);
    check("to_grant", 4'h4, 4'h0, 8'hCC, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 4'h0, 32'h0, 1'b0);
    check("to_start", 4'h0, 4'h0, 8'hCC, 1'b1, 1'b1, 2'd2, 1'b0);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 4'h0, 32'h0, 1'b0);
      if (i < 16)
        check($sformatf("to_wait%0d", i), 4'h0, 4'h0, 8'hCC, 1'b0, 1'b1, 2'd2, 1'b0);
      else
        check("to_expire", 4'h0, 4'h4, 8'hCC, 1'b0, 1'b0, 2'd2, 1'b1);
    end
    step(1'b1, 4'h0, 32'h0, 1'b0);
    check("to_after", 4'h0, 4'h0, 8'hCC, 1'b0, 1'b0, 2'd2, 1'b0);
`else
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 4'h0, 32'h0, 1'b0);
      check($sformatf("to_wait%0d", i), 4'h0, 4'h0, 8'hCC, 1'b0, 1'b1, 2'd2, 1'b0);
    end
    step(1'b1, 4'h0, 32'h0, 1'b1);
    check("to_late_done", 4'h0, 4'h4, 8'hCC, 1'b0, 1'b0, 2'd2, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
